// File: rtl/id_ex_stage.sv
// ID-side operand bypass, hazard detection and ID/EX pipeline latch.
// Feeds EX with forwarded operands or a bubble on stall/flush.
module id_ex_stage #(
   parameter int NB_BITS  = 32,
   parameter int NB_DEPTH = 5,
   parameter int NB_CTRL  = 12,
   parameter int NB_PERF  = 16
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_valid,
   input  logic [NB_BITS-1:0]  i_rs_data,
   input  logic [NB_BITS-1:0]  i_rt_data,
   input  logic [NB_DEPTH-1:0] i_rs_addr,
   input  logic [NB_DEPTH-1:0] i_rt_addr,
   input  logic                i_uses_rt,
   input  logic                i_is_branch,
   input  logic [NB_DEPTH-1:0] i_waddr,
   input  logic                i_wenb,
   input  logic [NB_BITS-1:0]  i_imm,
   input  logic [NB_CTRL-1:0]  i_ctrl,
   input  logic                i_flush,
   input  logic                i_ex_wenb,
   input  logic [NB_DEPTH-1:0] i_ex_waddr,
   input  logic                i_ex_is_load,
   input  logic                i_mem_wenb,
   input  logic [NB_DEPTH-1:0] i_mem_waddr,
   input  logic                i_mem_is_load,
   input  logic [NB_BITS-1:0]  i_mem_data,
   input  logic                i_wb_wenb,
   input  logic [NB_DEPTH-1:0] i_wb_waddr,
   input  logic [NB_BITS-1:0]  i_wb_data,
   output logic                o_stall,
   output logic                o_branch_eq,
   output logic                o_ex_valid,
   output logic [NB_BITS-1:0]  o_ex_rs,
   output logic [NB_BITS-1:0]  o_ex_rt,
   output logic [NB_BITS-1:0]  o_ex_imm,
   output logic [NB_DEPTH-1:0] o_ex_waddr,
   output logic                o_ex_wenb,
   output logic [NB_CTRL-1:0]  o_ex_ctrl,
   output logic [NB_PERF-1:0]  o_stall_count
);

   logic [NB_BITS-1:0] rs_fwd;
   logic [NB_BITS-1:0] rt_fwd;
   logic mem_fwd_rs, mem_fwd_rt;
   logic wb_fwd_rs, wb_fwd_rt;
   logic ex_rs, ex_rt;
   logic mld_rs, mld_rt;
   logic load_use, br_haz;
   logic capture;

   // r0 is hardwired, so it is never a bypass target
   assign mem_fwd_rs = i_mem_wenb && !i_mem_is_load
                       && i_rs_addr != '0
                       && i_mem_waddr == i_rs_addr;
   assign mem_fwd_rt = i_mem_wenb && !i_mem_is_load
                       && i_rt_addr != '0
                       && i_mem_waddr == i_rt_addr;
   assign wb_fwd_rs  = i_wb_wenb && i_rs_addr != '0
                       && i_wb_waddr == i_rs_addr;
   assign wb_fwd_rt  = i_wb_wenb && i_rt_addr != '0
                       && i_wb_waddr == i_rt_addr;

   always_comb begin
      rs_fwd = i_rs_data;
      if (mem_fwd_rs)
         rs_fwd = i_mem_data;
      else if (wb_fwd_rs)
         rs_fwd = i_wb_data;
   end

   always_comb begin
      rt_fwd = i_rt_data;
      if (mem_fwd_rt)
         rt_fwd = i_mem_data;
      else if (wb_fwd_rt)
         rt_fwd = i_wb_data;
   end

   assign ex_rs  = i_ex_wenb && i_ex_waddr != '0
                   && i_ex_waddr == i_rs_addr;
   assign ex_rt  = i_ex_wenb && i_ex_waddr != '0
                   && i_ex_waddr == i_rt_addr;
   assign mld_rs = i_mem_wenb && i_mem_is_load
                   && i_mem_waddr != '0
                   && i_mem_waddr == i_rs_addr;
   assign mld_rt = i_mem_wenb && i_mem_is_load
                   && i_mem_waddr != '0
                   && i_mem_waddr == i_rt_addr;

   assign load_use = i_valid && i_ex_is_load
                     && (ex_rs || (i_uses_rt && ex_rt));
   // branches compare in ID, so any producer still in EX or a load in MEM blocks them
   assign br_haz   = i_valid && i_is_branch
                     && (ex_rs || ex_rt || mld_rs || mld_rt);

   assign o_stall     = (load_use || br_haz) && !i_flush;
   assign o_branch_eq = (rs_fwd == rt_fwd);
   assign capture     = i_valid && !i_flush && !o_stall;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_ex_valid <= 1'b0;
         o_ex_rs    <= '0;
         o_ex_rt    <= '0;
         o_ex_imm   <= '0;
         o_ex_waddr <= '0;
         o_ex_wenb  <= 1'b0;
         o_ex_ctrl  <= '0;
      end else if (capture) begin
         o_ex_valid <= 1'b1;
         o_ex_rs    <= rs_fwd;
         o_ex_rt    <= rt_fwd;
         o_ex_imm   <= i_imm;
         o_ex_waddr <= i_waddr;
         o_ex_wenb  <= i_wenb;
         o_ex_ctrl  <= i_ctrl;
      end else begin
         o_ex_valid <= 1'b0;
         o_ex_rs    <= '0;
         o_ex_rt    <= '0;
         o_ex_imm   <= '0;
         o_ex_waddr <= '0;
         o_ex_wenb  <= 1'b0;
         o_ex_ctrl  <= '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)
         o_stall_count <= '0;
      else if (o_stall && o_stall_count != '1)
         o_stall_count <= o_stall_count + 1'b1;
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected latch contents are queued
// when each instruction is presented and compared after the clock edge.
module tb_id_ex_stage;

   typedef struct packed {
      logic        v;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [4:0]  wa;
      logic        we;
      logic [11:0] ctrl;
   } ex_t;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic [31:0] i_rs_data, i_rt_data;
   logic [4:0]  i_rs_addr, i_rt_addr;
   logic        i_uses_rt, i_is_branch;
   logic [4:0]  i_waddr;
   logic        i_wenb;
   logic [31:0] i_imm;
   logic [11:0] i_ctrl;
   logic        i_flush;
   logic        i_ex_wenb, i_ex_is_load;
   logic [4:0]  i_ex_waddr;
   logic        i_mem_wenb, i_mem_is_load;
   logic [4:0]  i_mem_waddr;
   logic [31:0] i_mem_data;
   logic        i_wb_wenb;
   logic [4:0]  i_wb_waddr;
   logic [31:0] i_wb_data;
   logic        o_stall, o_branch_eq;
   logic        o_ex_valid;
   logic [31:0] o_ex_rs, o_ex_rt, o_ex_imm;
   logic [4:0]  o_ex_waddr;
   logic        o_ex_wenb;
   logic [11:0] o_ex_ctrl;
   logic [15:0] o_stall_count;

   int   checks = 0;
   int   errors = 0;
   ex_t  sb[$];
   ex_t  bub;

   always #5 i_clk = ~i_clk;

   id_ex_stage dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid),
      .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
      .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr),
      .i_uses_rt(i_uses_rt), .i_is_branch(i_is_branch),
      .i_waddr(i_waddr), .i_wenb(i_wenb),
      .i_imm(i_imm), .i_ctrl(i_ctrl), .i_flush(i_flush),
      .i_ex_wenb(i_ex_wenb), .i_ex_waddr(i_ex_waddr),
      .i_ex_is_load(i_ex_is_load),
      .i_mem_wenb(i_mem_wenb), .i_mem_waddr(i_mem_waddr),
      .i_mem_is_load(i_mem_is_load), .i_mem_data(i_mem_data),
      .i_wb_wenb(i_wb_wenb), .i_wb_waddr(i_wb_waddr),
      .i_wb_data(i_wb_data),
      .o_stall(o_stall), .o_branch_eq(o_branch_eq),
      .o_ex_valid(o_ex_valid), .o_ex_rs(o_ex_rs),
      .o_ex_rt(o_ex_rt), .o_ex_imm(o_ex_imm),
      .o_ex_waddr(o_ex_waddr), .o_ex_wenb(o_ex_wenb),
      .o_ex_ctrl(o_ex_ctrl), .o_stall_count(o_stall_count)
   );

   function automatic ex_t mk(
      logic [31:0] rs, logic [31:0] rt, logic [31:0] imm,
      logic [4:0] wa, logic we, logic [11:0] ctrl);
      ex_t e;
      e = '{v: 1'b1, rs: rs, rt: rt, imm: imm,
            wa: wa, we: we, ctrl: ctrl};
      return e;
   endfunction

   task automatic quiet();
      i_flush = 0; i_is_branch = 0;
      i_ex_wenb = 0; i_ex_waddr = 0; i_ex_is_load = 0;
      i_mem_wenb = 0; i_mem_waddr = 0; i_mem_is_load = 0;
      i_mem_data = 0;
      i_wb_wenb = 0; i_wb_waddr = 0; i_wb_data = 0;
   endtask

   task automatic instr(
      logic [4:0] rs, logic [31:0] rsd,
      logic [4:0] rt, logic [31:0] rtd, logic urt,
      logic [31:0] imm, logic [4:0] wa, logic we,
      logic [11:0] ctrl);
      i_valid = 1;
      i_rs_addr = rs; i_rs_data = rsd;
      i_rt_addr = rt; i_rt_data = rtd; i_uses_rt = urt;
      i_imm = imm; i_waddr = wa; i_wenb = we; i_ctrl = ctrl;
   endtask

   task automatic cyc(
      string tag, logic es, logic cb, logic eb, ex_t exp);
      ex_t e;
      ex_t g;
      #1;
      checks++;
      assert (o_stall === es) else begin
         errors++;
         $error("FAIL %s stall got %0b exp %0b",
                tag, o_stall, es);
      end
      if (cb) begin
         checks++;
         assert (o_branch_eq === eb) else begin
            errors++;
            $error("FAIL %s beq got %0b exp %0b",
                   tag, o_branch_eq, eb);
         end
      end
      sb.push_back(exp);
      @(posedge i_clk);
      #1;
      e = sb.pop_front();
      g = '{v: o_ex_valid, rs: o_ex_rs, rt: o_ex_rt,
            imm: o_ex_imm, wa: o_ex_waddr, we: o_ex_wenb,
            ctrl: o_ex_ctrl};
      checks++;
      assert (g === e) else begin
         errors++;
         $error("FAIL %s latch got %h exp %h", tag, g, e);
      end
   endtask

   task automatic cnt(string tag, logic [15:0] exp);
      checks++;
      assert (o_stall_count === exp) else begin
         errors++;
         $error("FAIL %s count got %0d exp %0d",
                tag, o_stall_count, exp);
      end
   endtask

   initial begin
      bub = '0;
      quiet();
      instr(5'd2, 32'h55, 5'd6, 32'h66, 1, 32'h1,
            5'd9, 1, 12'hFFF);
      i_rst = 1;
      @(posedge i_clk);
      #1;
      cyc("rst0", 0, 0, 0, bub);
      cyc("rst1", 0, 0, 0, bub);
      cnt("rst_cnt", 16'd0);
      i_rst = 0;

      // MEM result beats WB, which beats stale regfile
      quiet();
      i_mem_wenb = 1; i_mem_waddr = 3; i_mem_data = 32'h22;
      i_wb_wenb = 1; i_wb_waddr = 3; i_wb_data = 32'h33;
      instr(5'd3, 32'h11, 5'd0, 32'h0, 0, 32'h10,
            5'd9, 1, 12'h0A5);
      cyc("mem_fwd", 0, 0, 0,
          mk(32'h22, 0, 32'h10, 5'd9, 1, 12'h0A5));

      // load in MEM is not a bypass source: WB wins
      i_mem_is_load = 1;
      cyc("mem_ld_nofwd", 0, 0, 0,
          mk(32'h33, 0, 32'h10, 5'd9, 1, 12'h0A5));

      quiet();
      i_mem_wenb = 1; i_mem_waddr = 0; i_mem_data = 32'h99;
      i_wb_wenb = 1; i_wb_waddr = 5; i_wb_data = 32'hAB;
      instr(5'd0, 32'h0, 5'd5, 32'h44, 1, 32'hFFFF_FFF0,
            5'd10, 1, 12'h123);
      cyc("wb_fwd_r0", 0, 0, 0,
          mk(0, 32'hAB, 32'hFFFF_FFF0, 5'd10, 1, 12'h123));

      i_valid = 0;
      cyc("not_valid", 0, 0, 0, bub);

      // lw r7 in EX, add r8,r7,r1 in ID
      quiet();
      i_ex_wenb = 1; i_ex_waddr = 7; i_ex_is_load = 1;
      instr(5'd7, 32'h70, 5'd1, 32'h01, 1, 32'h0,
            5'd8, 1, 12'h001);
      cyc("lu_stall", 1, 0, 0, bub);
      cnt("lu_cnt", 16'd1);
      quiet();
      i_mem_wenb = 1; i_mem_waddr = 7; i_mem_data = 32'h77;
      cyc("lu_resume", 0, 0, 0,
          mk(32'h77, 32'h01, 0, 5'd8, 1, 12'h001));

      // reset during a stall: stall still visible, all cleared
      quiet();
      i_ex_wenb = 1; i_ex_waddr = 7; i_ex_is_load = 1;
      i_rst = 1;
      cyc("rst_stall", 1, 0, 0, bub);
      cnt("rst_stall_cnt", 16'd0);
      i_rst = 0;

      // add r4 in EX, beq r4,r4 in ID
      quiet();
      i_ex_wenb = 1; i_ex_waddr = 4;
      i_is_branch = 1;
      instr(5'd4, 32'h40, 5'd4, 32'h41, 1, 32'h8,
            5'd0, 0, 12'h800);
      cyc("br_ex", 1, 0, 0, bub);
      i_ex_wenb = 0; i_ex_waddr = 0;
      i_mem_wenb = 1; i_mem_waddr = 4; i_mem_data = 32'h444;
      cyc("br_mem_fwd", 0, 1, 1,
          mk(32'h444, 32'h444, 32'h8, 5'd0, 0, 12'h800));

      // beq r4,r5 with only r4 bypassed: not equal
      i_rt_addr = 5; i_rt_data = 32'h445;
      cyc("br_ne", 0, 1, 0,
          mk(32'h444, 32'h445, 32'h8, 5'd0, 0, 12'h800));

      // lw r4 ahead of beq r4,r4: two stall cycles
      quiet();
      i_is_branch = 1;
      i_rt_addr = 4; i_rt_data = 32'h41;
      i_ex_wenb = 1; i_ex_waddr = 4; i_ex_is_load = 1;
      cyc("br_ld_ex", 1, 0, 0, bub);
      i_ex_wenb = 0; i_ex_waddr = 0; i_ex_is_load = 0;
      i_mem_wenb = 1; i_mem_waddr = 4; i_mem_is_load = 1;
      i_mem_data = 32'h123;
      cyc("br_ld_mem", 1, 0, 0, bub);
      i_mem_wenb = 0; i_mem_waddr = 0; i_mem_is_load = 0;
      i_wb_wenb = 1; i_wb_waddr = 4; i_wb_data = 32'h555;
      cyc("br_ld_wb", 0, 1, 1,
          mk(32'h555, 32'h555, 32'h8, 5'd0, 0, 12'h800));
      cnt("br_cnt", 16'd3);

      // flush overrides load-use stall
      quiet();
      i_ex_wenb = 1; i_ex_waddr = 7; i_ex_is_load = 1;
      instr(5'd7, 32'h70, 5'd1, 32'h01, 1, 32'h0,
            5'd8, 1, 12'h001);
      i_flush = 1;
      cyc("flush_stall", 0, 0, 0, bub);
      cnt("flush_cnt", 16'd3);

      // rt hazard ignored when rt is not read
      i_flush = 0;
      instr(5'd2, 32'h20, 5'd7, 32'h70, 0, 32'h4,
            5'd7, 1, 12'h040);
      cyc("no_rt_use", 0, 0, 0,
          mk(32'h20, 32'h70, 32'h4, 5'd7, 1, 12'h040));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
